// File: rtl/jb_dl_dfe_nco_mixer_if.sv
// Sample stream bundle for the per-antenna NCO mixer: time-delay stage drives
// samples and NCO controls in, rotated samples come out.
interface jb_dl_dfe_nco_mixer_if #(
  parameter int N_ANTENNAS = 4,
  parameter int PRECISION  = 16,
  parameter int PHASE_BITS = 32
);
  logic [N_ANTENNAS-1:0]   tvalid_in;
  logic [2*PRECISION-1:0]  tdata_in     [N_ANTENNAS];
  logic [PHASE_BITS-1:0]   freq_word    [N_ANTENNAS];
  logic [PHASE_BITS-1:0]   phase_offset [N_ANTENNAS];
  logic                    nco_update;
  logic                    phase_clr;
  logic [N_ANTENNAS-1:0]   tvalid_out;
  logic [2*PRECISION-1:0]  tdata_out    [N_ANTENNAS];

  modport master (
    output tvalid_in, tdata_in, freq_word, phase_offset, nco_update, phase_clr,
    input  tvalid_out, tdata_out
  );

  modport slave (
    input  tvalid_in, tdata_in, freq_word, phase_offset, nco_update, phase_clr,
    output tvalid_out, tdata_out
  );
endinterface

// File: rtl/jb_dl_dfe_nco_mixer.sv
// Per-antenna NCO + complex mixer, 4-stage pipeline (phase, table, multiply, round/sat).
// Optional phase dither from a 16-bit LFSR when JB_NCO_DITHER_EN is defined.
module jb_dl_dfe_nco_mixer #(
  parameter int N_ANTENNAS    = 4,
  parameter int PRECISION     = 16,
  parameter int PHASE_BITS    = 32,
  parameter int LUT_ADDR_BITS = 10
) (
  input  logic                 clk_1x,
  input  logic                 resetn_1x,
  jb_dl_dfe_nco_mixer_if.slave nco_if
);

  localparam int LUT_DEPTH = 2 ** LUT_ADDR_BITS;
  localparam int COEF_W    = 16;
  localparam int PROD_W    = PRECISION + COEF_W;
  localparam int SUM_W     = PROD_W + 1;
  localparam logic signed [SUM_W:0] RND_BIAS = (SUM_W + 1)'(2 ** (COEF_W - 2));
  localparam logic signed [SUM_W:0] SAT_MAX  = (SUM_W + 1)'(2 ** (PRECISION - 1) - 1);
  localparam logic signed [SUM_W:0] SAT_MIN  = (SUM_W + 1)'(-(2 ** (PRECISION - 1)));

  // Half-up rounding: bias by half an LSB of the Q15 coefficient, then drop 15 bits.
  function automatic logic signed [SUM_W:0] rnd_half_up(input logic signed [SUM_W-1:0] x);
    logic signed [SUM_W:0] t;
    t = {x[SUM_W-1], x} + RND_BIAS;
    return t >>> (COEF_W - 1);
  endfunction

  function automatic logic signed [PRECISION-1:0] sat(input logic signed [SUM_W:0] x);
    if (x > SAT_MAX)      return SAT_MAX[PRECISION-1:0];
    else if (x < SAT_MIN) return SAT_MIN[PRECISION-1:0];
    else                  return x[PRECISION-1:0];
  endfunction

  // Full-wave Q15 cos/sin tables, evaluated at elaboration.
  logic signed [COEF_W-1:0] cos_lut [LUT_DEPTH];
  logic signed [COEF_W-1:0] sin_lut [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam real ANG   = 6.283185307179586 * real'(k) / real'(LUT_DEPTH);
    localparam int  COS_V = int'(32767.0 * $cos(ANG));
    localparam int  SIN_V = int'(32767.0 * $sin(ANG));
    assign cos_lut[k] = COEF_W'(COS_V);
    assign sin_lut[k] = COEF_W'(SIN_V);
  end

  logic [PHASE_BITS-1:0] dither_c;

`ifdef JB_NCO_DITHER_EN
  localparam int DITHER_SHIFT = PHASE_BITS - LUT_ADDR_BITS - 16;
  logic [15:0] lfsr_r;

  always_ff @(posedge clk_1x or negedge resetn_1x) begin
    if (!resetn_1x) lfsr_r <= 16'hACE1;
    else            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
  end

  assign dither_c = PHASE_BITS'(lfsr_r) << DITHER_SHIFT;
`else
  assign dither_c = '0;
`endif

  for (genvar i = 0; i < N_ANTENNAS; i++) begin : g_lane
    logic [PHASE_BITS-1:0]        freq_r, off_r, acc_r, phase_c;
    logic                         vld_p0, vld_p1, vld_p2, vld_p3;
    logic [LUT_ADDR_BITS-1:0]     idx_p0;
    logic signed [PRECISION-1:0]  i_p0, q_p0, i_p1, q_p1, i_p3, q_p3;
    logic signed [COEF_W-1:0]     cos_p1, sin_p1;
    logic signed [PROD_W-1:0]     ic_p2, qs_p2, is_p2, qc_p2;
    logic signed [SUM_W-1:0]      i_sum_c, q_sum_c;
    logic                         unused_phase_lsbs;

    assign phase_c           = acc_r + off_r + dither_c;
    assign unused_phase_lsbs = ^phase_c[PHASE_BITS-LUT_ADDR_BITS-1:0];
    assign i_sum_c           = SUM_W'(ic_p2) - SUM_W'(qs_p2);
    assign q_sum_c           = SUM_W'(is_p2) + SUM_W'(qc_p2);

    always_ff @(posedge clk_1x or negedge resetn_1x) begin
      if (!resetn_1x) begin
        freq_r <= '0;  off_r  <= '0;  acc_r  <= '0;
        vld_p0 <= 1'b0; vld_p1 <= 1'b0; vld_p2 <= 1'b0; vld_p3 <= 1'b0;
        idx_p0 <= '0;  i_p0   <= '0;  q_p0   <= '0;
        cos_p1 <= '0;  sin_p1 <= '0;  i_p1   <= '0;  q_p1 <= '0;
        ic_p2  <= '0;  qs_p2  <= '0;  is_p2  <= '0;  qc_p2 <= '0;
        i_p3   <= '0;  q_p3   <= '0;
      end else begin
        // A same-cycle sample has already used the old freq/offset via phase_c.
        if (nco_if.nco_update) begin
          freq_r <= nco_if.freq_word[i];
          off_r  <= nco_if.phase_offset[i];
        end
        if (nco_if.nco_update && nco_if.phase_clr) acc_r <= '0;
        else if (nco_if.tvalid_in[i])             acc_r <= acc_r + freq_r;

        // Stage 0: phase register
        vld_p0 <= nco_if.tvalid_in[i];
        idx_p0 <= phase_c[PHASE_BITS-1 -: LUT_ADDR_BITS];
        i_p0   <= nco_if.tdata_in[i][PRECISION-1:0];
        q_p0   <= nco_if.tdata_in[i][2*PRECISION-1:PRECISION];

        // Stage 1: table read
        vld_p1 <= vld_p0;
        cos_p1 <= cos_lut[idx_p0];
        sin_p1 <= sin_lut[idx_p0];
        i_p1   <= i_p0;
        q_p1   <= q_p0;

        // Stage 2: multiply
        vld_p2 <= vld_p1;
        ic_p2  <= i_p1 * cos_p1;
        qs_p2  <= q_p1 * sin_p1;
        is_p2  <= i_p1 * sin_p1;
        qc_p2  <= q_p1 * cos_p1;

        // Stage 3: add, round, saturate; output holds between valid samples
        vld_p3 <= vld_p2;
        if (vld_p2) begin
          i_p3 <= sat(rnd_half_up(i_sum_c));
          q_p3 <= sat(rnd_half_up(q_sum_c));
        end
      end
    end

    assign nco_if.tvalid_out[i] = vld_p3;
    assign nco_if.tdata_out[i]  = {q_p3, i_p3};
  end

endmodule

// File: doc/jb_dl_dfe_nco_mixer.md
JB_DL_DFE_NCO_MIXER -- requirements
Module: jb_dl_dfe_nco_mixer

Interface
REQ-001 Parameters SHALL be: N_ANTENNAS, default 4, antenna lanes; PRECISION, default 16, I/Q component width; PHASE_BITS, default 32, accumulator width; LUT_ADDR_BITS, default 10, sin/cos table index width.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, named clk_1x and resetn_1x.
REQ-003 Ports SHALL be:
- clk_1x  in  1  122.88 MHz clock.
- resetn_1x  in  1  async active-low reset.
- tvalid_in  in  N_ANTENNAS  per-antenna sample valid, fed by the time-delay stage.
- tdata_in[N_ANTENNAS]  in  2*PRECISION  {Q,I} signed samples.
- freq_word[N_ANTENNAS]  in  PHASE_BITS  phase increment per valid sample.
- phase_offset[N_ANTENNAS]  in  PHASE_BITS  static phase offset.
- nco_update  in  1  single-cycle pulse that loads freq_word and phase_offset.
- phase_clr  in  1  qualified by nco_update; clears all accumulators.
- tvalid_out  out  N_ANTENNAS  per-antenna output valid.
- tdata_out[N_ANTENNAS]  out  2*PRECISION  {Q,I} rotated samples.

Function
REQ-004 Each lane SHALL keep an active freq register, an active offset register and a PHASE_BITS accumulator, all independent per lane.
REQ-005 On a cycle with nco_update=1, active registers SHALL load freq_word/phase_offset; a sample valid in that same cycle SHALL use the old values.
REQ-006 A sample valid in the cycle after the update SHALL be the first to use the new values.
REQ-007 Sample phase SHALL be acc+offset (mod 2^PHASE_BITS); acc SHALL then advance by freq only on cycles with tvalid_in=1, wrapping modulo 2^PHASE_BITS.
REQ-008 nco_update=1 with phase_clr=1 SHALL set every accumulator to 0 on that edge, taking precedence over the increment; the first sample after the update SHALL use phase = new offset.
REQ-009 The table index SHALL be the top LUT_ADDR_BITS bits of the sample phase, truncated.
REQ-010 The cos/sin table SHALL hold round(32767*cos/sin(2*pi*k/2^LUT_ADDR_BITS)), signed 16-bit.
REQ-011 Output SHALL be I'=I*cos-Q*sin and Q'=I*sin+Q*cos, using full-precision 33-bit sums.
REQ-012 Each component SHALL be rounded half-up by adding 2^14 and arithmetic-shifting right by 15, then saturated to [-32768, 32767].
REQ-013 Pipeline: phase register, table read, multiply, add/round/saturate; tvalid_out SHALL equal tvalid_in delayed exactly 4 cycles per lane, with no bubbles and no backpressure.
REQ-014 tdata_out SHALL hold its last value when tvalid_out=0.
REQ-015 Lanes with tvalid_in=0 SHALL NOT advance their accumulator or emit tvalid_out.

Reset
REQ-016 While resetn_1x=0, accumulators, active freq/offset, pipeline data, tvalid_out and tdata_out SHALL all be 0.
REQ-017 Assertion of reset mid-stream SHALL flush the pipeline immediately; samples in flight are discarded and produce no tvalid_out.
REQ-018 After release, the first valid sample SHALL see phase 0 and frequency 0, i.e. pass through unchanged apart from the 32767/32768 gain.

Configuration
REQ-019 With macro JB_NCO_DITHER_EN defined, a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset, stepping every cycle) SHALL be added, left-shifted by (PHASE_BITS-LUT_ADDR_BITS-16), to the sample phase before truncation.
REQ-020 Without JB_NCO_DITHER_EN, no LFSR SHALL exist and the phase SHALL be truncated undithered.
REQ-021 Latency SHALL be 4 cycles in both builds.

Verification
REQ-022 Bench SHALL build without JB_NCO_DITHER_EN and SHALL cover:
- Reset release, freq=0, offset=0, input I=1000, Q=0 -> output (1000,0), tvalid_out exactly 4 cycles after tvalid_in.
- nco_update with freq=2^30 and phase_clr=1, then four valid samples of (1000,0) -> (1000,0), (0,1000), (-1000,0), (0,-1000).
- Sample valid in the same cycle as nco_update (freq 0->2^30) -> that sample uses freq 0; later samples rotate 90 degrees each.
- offset=2^29, input I=32767, Q=-32768 -> I' saturates to 32767, Q'=-1.
- Lane 0 valid every cycle, lane 1 valid every third cycle, both freq=2^30 -> each lane cycles through its four rotations per its own valid samples only.
- resetn_1x asserted with 3 samples in flight -> tvalid_out stays 0, and all outputs read 0 after release.
